fetch_unit: RTL
===============

# fetch_unit

Instruction fetch front end that drives the word-indexed `PC` into the instruction queue and captures the instruction it returns one cycle later. Returned instructions, tagged with their PC, go into a small FIFO that feeds decode through a valid/ready handshake. A single-cycle `redirect` from the branch predictor or the execute stage restarts fetch at a new PC and discards everything queued or in flight.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥ 3.
- `RESET_PC`, 32'h0: PC loaded on reset.

Ports:
- `clk` in 1: sole clock; all state updates on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `PC` out 32: word index presented to the instruction queue; registered.
- `instr_in` in 32: instruction queue output; holds `InstrRAM[PC]` as sampled at the previous posedge.
- `redirect` in 1: flush and restart request, one-cycle pulse.
- `redirect_pc` in 32: restart PC, valid with `redirect`.
- `out_valid` out 1: FIFO head valid.
- `out_ready` in 1: decode accepts head.
- `out_instr` out 32: head instruction.
- `out_pc` out 32: head PC.
- `fetch_count` out 32: pushes since reset (see Configuration).
- `flush_count` out 32: redirects since reset (see Configuration).

## Operation
- State: `PC` register, `inflight_valid`/`inflight_pc` register, FIFO (`DEPTH` entries of {instr, pc}, read ptr, write ptr, count of width log2(DEPTH)+1).
- Issue: `issue = (count + inflight_valid) < DEPTH`. This count is conservative and ignores a same-cycle pop. On an issue edge: `inflight_valid<=1`, `inflight_pc<=PC`, `PC<=PC+1` (32-bit wrap, 32'hFFFFFFFF→0). With no issue, `PC` holds and `inflight_valid<=0`.
- Capture: at an edge with `inflight_valid=1`, push {`instr_in`, `inflight_pc`} into the FIFO.
- Pop: at an edge with `out_valid & out_ready`, advance read ptr. Push and pop in the same cycle leave `count` unchanged.
- `out_instr`/`out_pc` are combinational from the head entry. Entry storage resets to 0.
- Redirect has priority over every other action. At an edge with `redirect=1`: `PC<=redirect_pc`, FIFO emptied (pointers and count to 0), `inflight_valid<=0`, so the in-flight response is dropped. No push and no pop occur that cycle. A handshake shown on the same cycle does not count as consumed.
- Pointers wrap modulo `DEPTH`.
- Reset (async, any time): `PC=RESET_PC`, FIFO empty, `inflight_valid=0`, `out_valid=0`, `out_instr=0`, `out_pc=0`, both counters 0.

## Timing
- Issue→`out_valid`: 2 edges. Edge 1 latches the PC into memory and the in-flight register. Edge 2 pushes into the FIFO.
- First `out_valid` comes 2 edges after `rst_n` rises: `out_pc=RESET_PC`.
- Sustained throughput is 1 instr/cycle with `out_ready=1`. Steady state is count=1, inflight=1.
- With `out_ready=0`, the FIFO fills to exactly `DEPTH` and `PC` stops at the first un-issued address.
- After a redirect edge, `out_valid=0` for 2 cycles. The first new head has `out_pc=redirect_pc`.
- The `PC` change is visible to memory at the next edge. No combinational path exists from `redirect` or `out_ready` to `PC`.

## Configuration
- `FETCH_STATS_EN` defined:
  - `fetch_count` increments on every FIFO push.
  - `flush_count` increments on every redirect edge.
  - Both are 32-bit and wrap.
- `FETCH_STATS_EN` undefined:
  - Counter logic is not compiled in.
  - Both ports are tied to 0.

## Test plan
- Streaming: reset, memory word i = 32'h100+i, `out_ready=1`. `out_valid` rises 2 edges after reset release, then `out_pc` = 0,1,2,3,… and `out_instr` = 32'h100,… on consecutive cycles.
- Backpressure: `out_ready=0` from start with DEPTH=4. FIFO holds PCs 0–3 and `PC` parks at 4. Raise `out_ready`: PCs 0,1,2,3,4,5… appear in order with no gap or duplicate.
- Redirect: with 3 entries queued and PC 3 in flight, pulse `redirect` with `redirect_pc=32'h10`. `out_valid=0` the next cycle, PC 3 is never output, and the next head is `out_pc=32'h10` 2 edges later.
- Redirect versus pop: `redirect` and `out_valid&out_ready` on the same edge. FIFO is empty afterwards, with no stale entry and no count underflow.
- Async reset mid-stream: drop `rst_n` between edges. `out_valid=0` and `PC=RESET_PC` immediately, without waiting for `clk`.
- Stats (`FETCH_STATS_EN`): after the redirect scenario, `flush_count=1` and `fetch_count` equals the number of pushes observed. Without the macro, both read 0 throughout.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch front end: registered PC, one in-flight slot, {instr,pc} FIFO to decode.
// Define FETCH_STATS_EN to compile in the fetch_count / flush_count statistics counters.
module fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] PC,
    input  logic [31:0] instr_in,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] fetch_count,
    output logic [31:0] flush_count
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [31:0]   r_pc;
    logic          r_inflight_valid;
    logic [31:0]   r_inflight_pc;
    logic [31:0]   r_instr_q [DEPTH];
    logic [31:0]   r_pc_q    [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [PW:0]   r_count;

    logic [PW+1:0] w_occupancy;
    logic          w_issue;
    logic          w_push;
    logic          w_pop;

    // Occupancy ignores a same-cycle pop, so a full FIFO stalls issue for one extra cycle.
    always_comb begin
        w_occupancy = {1'b0, r_count} + {{(PW+1){1'b0}}, r_inflight_valid};
        w_issue     = w_occupancy < (PW+2)'(DEPTH);
        w_push      = !redirect && r_inflight_valid;
        w_pop       = !redirect && out_valid && out_ready;
    end

    assign PC        = r_pc;
    assign out_valid = (r_count != '0);
    assign out_instr = r_instr_q[r_rd_ptr];
    assign out_pc    = r_pc_q[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc             <= RESET_PC;
            r_inflight_valid <= 1'b0;
            r_inflight_pc    <= '0;
        end else if (redirect) begin
            r_pc             <= redirect_pc;
            r_inflight_valid <= 1'b0;
        end else if (w_issue) begin
            r_pc             <= r_pc + 32'd1;
            r_inflight_valid <= 1'b1;
            r_inflight_pc    <= r_pc;
        end else begin
            r_inflight_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_instr_q[i] <= '0;
                r_pc_q[i]    <= '0;
            end
        end else if (w_push) begin
            r_instr_q[r_wr_ptr] <= instr_in;
            r_pc_q[r_wr_ptr]    <= r_inflight_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (redirect) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_flush_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_count <= '0;
            r_flush_count <= '0;
        end else begin
            if (w_push)   r_fetch_count <= r_fetch_count + 32'd1;
            if (redirect) r_flush_count <= r_flush_count + 32'd1;
        end
    end

    assign fetch_count = r_fetch_count;
    assign flush_count = r_flush_count;
`else
    assign fetch_count = '0;
    assign flush_count = '0;
`endif

endmodule
